// File: rtl/conv3x3_engine_if.sv
// rtl/conv3x3_engine_if.sv - Byte-lane input bus, control pulses and result outputs of the 3x3 convolution engine.
interface conv3x3_engine_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
);
  logic              load_filter;
  logic              start;
  logic [DATA_W-1:0] arr_in0,  arr_in1,  arr_in2,  arr_in3;
  logic [DATA_W-1:0] arr_in4,  arr_in5,  arr_in6,  arr_in7;
  logic [DATA_W-1:0] arr_in8,  arr_in9,  arr_in10, arr_in11;
  logic [DATA_W-1:0] arr_in12, arr_in13, arr_in14, arr_in15;
  logic              busy;
  logic              done;
  logic              filter_loaded;
  logic [ACC_W-1:0]  result0, result1, result2, result3;

  modport master (
    output load_filter, start,
    output arr_in0, arr_in1, arr_in2, arr_in3, arr_in4, arr_in5, arr_in6, arr_in7,
    output arr_in8, arr_in9, arr_in10, arr_in11, arr_in12, arr_in13, arr_in14, arr_in15,
    input  busy, done, filter_loaded, result0, result1, result2, result3
  );

  modport slave (
    input  load_filter, start,
    input  arr_in0, arr_in1, arr_in2, arr_in3, arr_in4, arr_in5, arr_in6, arr_in7,
    input  arr_in8, arr_in9, arr_in10, arr_in11, arr_in12, arr_in13, arr_in14, arr_in15,
    output busy, done, filter_loaded, result0, result1, result2, result3
  );
endinterface

// File: rtl/conv3x3_engine.sv
// rtl/conv3x3_engine.sv - 3x3 filter over a 4x4 matrix, four 2x2 outputs, one shared MAC per clock.
module conv3x3_engine #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic             clk,
  input  logic             rst,
  conv3x3_engine_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] f_q [9];
  logic [DATA_W-1:0] f_d [9];
  logic [DATA_W-1:0] m_q [16];
  logic [DATA_W-1:0] m_d [16];
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [1:0]        pos_q, pos_d;
  logic [3:0]        tap_q, tap_d;
  logic [ACC_W-1:0]  res_q [4];
  logic [ACC_W-1:0]  res_d [4];
  logic              fl_q, fl_d;

  logic [DATA_W-1:0]   lane [16];
  logic [1:0]          ti, tj;
  logic [1:0]          row, col;
  logic [DATA_W-1:0]   f_sel, m_sel;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    acc_sum;

  assign lane[0]  = bus.arr_in0;   assign lane[1]  = bus.arr_in1;
  assign lane[2]  = bus.arr_in2;   assign lane[3]  = bus.arr_in3;
  assign lane[4]  = bus.arr_in4;   assign lane[5]  = bus.arr_in5;
  assign lane[6]  = bus.arr_in6;   assign lane[7]  = bus.arr_in7;
  assign lane[8]  = bus.arr_in8;   assign lane[9]  = bus.arr_in9;
  assign lane[10] = bus.arr_in10;  assign lane[11] = bus.arr_in11;
  assign lane[12] = bus.arr_in12;  assign lane[13] = bus.arr_in13;
  assign lane[14] = bus.arr_in14;  assign lane[15] = bus.arr_in15;

  // Tap t maps to filter row t/3 and column t%3.
  always_comb begin
    ti    = 2'd0;
    tj    = 2'd0;
    f_sel = '0;
    case (tap_q)
      4'd0: begin ti = 2'd0; tj = 2'd0; f_sel = f_q[0]; end
      4'd1: begin ti = 2'd0; tj = 2'd1; f_sel = f_q[1]; end
      4'd2: begin ti = 2'd0; tj = 2'd2; f_sel = f_q[2]; end
      4'd3: begin ti = 2'd1; tj = 2'd0; f_sel = f_q[3]; end
      4'd4: begin ti = 2'd1; tj = 2'd1; f_sel = f_q[4]; end
      4'd5: begin ti = 2'd1; tj = 2'd2; f_sel = f_q[5]; end
      4'd6: begin ti = 2'd2; tj = 2'd0; f_sel = f_q[6]; end
      4'd7: begin ti = 2'd2; tj = 2'd1; f_sel = f_q[7]; end
      4'd8: begin ti = 2'd2; tj = 2'd2; f_sel = f_q[8]; end
      default: begin ti = 2'd0; tj = 2'd0; f_sel = '0; end
    endcase
  end

  assign row     = {1'b0, pos_q[1]} + ti;
  assign col     = {1'b0, pos_q[0]} + tj;
  assign m_sel   = m_q[{row, col}];
  assign prod    = f_sel * m_sel;
  assign acc_sum = acc_q + {{(ACC_W-2*DATA_W){1'b0}}, prod};

  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    m_d     = m_q;
    acc_d   = acc_q;
    pos_d   = pos_q;
    tap_d   = tap_q;
    res_d   = res_q;
    fl_d    = fl_q;
    case (state_q)
      S_IDLE: begin
        // start takes priority: the lanes then carry matrix data.
        if (bus.start) begin
          m_d     = lane;
          acc_d   = '0;
          pos_d   = 2'd0;
          tap_d   = 4'd0;
          state_d = S_MAC;
        end else if (bus.load_filter) begin
          for (int i = 0; i < 9; i++) f_d[i] = lane[i];
          fl_d = 1'b1;
        end
      end
      S_MAC: begin
        if (tap_q == 4'd8) begin
          res_d[pos_q] = acc_sum;
          acc_d        = '0;
          tap_d        = 4'd0;
          pos_d        = pos_q + 2'd1;
          if (pos_q == 2'd3) state_d = S_DONE;
        end else begin
          acc_d = acc_sum;
          tap_d = tap_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < 9; i++)  f_q[i]   <= '0;
      for (int i = 0; i < 16; i++) m_q[i]   <= '0;
      for (int i = 0; i < 4; i++)  res_q[i] <= '0;
      acc_q   <= '0;
      pos_q   <= 2'd0;
      tap_q   <= 4'd0;
      fl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      m_q     <= m_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      pos_q   <= pos_d;
      tap_q   <= tap_d;
      fl_q    <= fl_d;
    end
  end

  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = (state_q == S_DONE);
  assign bus.filter_loaded = fl_q;
  assign bus.result0       = res_q[0];
  assign bus.result1       = res_q[1];
  assign bus.result2       = res_q[2];
  assign bus.result3       = res_q[3];
endmodule
